// File: rtl/bitcnt_pkg.sv
// Shared definitions for the bit-count arbiter: op encodings, FSM state,
// the latched request record and the bit-manipulation helpers used by the core.
package bitcnt_pkg;

    localparam logic [1:0] OP_CPOP = 2'b00;
    localparam logic [1:0] OP_CTZ  = 2'b01;
    localparam logic [1:0] OP_CLZ  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request as captured at grant time; op 11 is carried through and runs as cpop.
    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] rs1;
    } bc_req_t;

    function automatic logic [5:0] popcount32(input logic [31:0] x);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, x[i]};
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bitcnt_arbiter_if.sv
// Request/response bundle between the requesters and the shared bit-count unit.
// Requester i owns bit i of req_valid/req_ready, req_op[2i+1:2i] and
// req_rs1[XLEN*i +: XLEN]; the single response channel is tagged by rsp_id.
interface bitcnt_arbiter_if #(
    parameter int NREQ = 4,
    parameter int XLEN = 32,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_op;
    logic [XLEN*NREQ-1:0] req_rs1;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [XLEN-1:0]      rsp_rd;

    // Requester / response-consumer side
    modport master (
        output req_valid, req_op, req_rs1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_rd
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op, req_rs1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_rd
    );
endinterface

// File: rtl/bitcnt_core.sv
// Shared clz/ctz/cpop datapath with one registered stage.
// clz is folded into ctz by bit-reversing the operand; ctz is computed as the
// popcount of (x-1)&~x, which naturally yields 32 for a zero operand.
module bitcnt_core
    import bitcnt_pkg::*;
(
    input  logic        clock,
    input  logic        clz,
    input  logic        ctz,
    input  logic [31:0] rs1,
    output logic [31:0] rd
);

    logic [31:0] x;
    logic [31:0] sel;

    // Orient the operand, then pick either the trailing-zero mask or the raw value
    always_comb begin
        x   = clz ? bitrev32(rs1) : rs1;
        sel = (clz || ctz) ? ((x - 32'd1) & ~x) : x;
    end

    // Result register; inputs are held stable by the arbiter while it matters
    always_ff @(posedge clock) begin
        rd <= {26'd0, popcount32(sel)};
    end

endmodule

// File: rtl/bitcnt_arbiter.sv
// Round-robin arbiter sharing one bit-count core between NREQ requesters.
// One op in flight: IDLE (grant) -> EXEC (core computes) -> RESP (hold until taken).
// Optional statistics counters are built when BITCNT_ARB_STATS_EN is defined.
module bitcnt_arbiter
    import bitcnt_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int XLEN = 32,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic        clock,
    input  logic        resetn,
    bitcnt_arbiter_if.slave bus
`ifdef BITCNT_ARB_STATS_EN
    ,
    output logic [31:0] stat_ops,
    output logic [31:0] stat_stall
`endif
);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] lat_id;
    bc_req_t        lat;
    logic           rsp_valid_q;

    logic           grant_any;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand;
    int             idx;
    bc_req_t        sel_req;
    logic [IDW-1:0] ptr_next;
    logic [31:0]    core_rd;

    // Rotating priority search starting at ptr; lowest offset wins
    always_comb begin
        grant_any = 1'b0;
        grant_id  = ptr;
        idx       = 0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // Mux the granted requester's op/operand with constant slices
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_req.op  = bus.req_op[2*i +: 2];
                sel_req.rs1 = bus.req_rs1[XLEN*i +: XLEN];
            end
        end
    end

    // Ready is only offered from IDLE and never while reset is asserted
    always_comb begin
        bus.req_ready = '0;
        if (resetn && state == IDLE && grant_any) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    assign ptr_next = (lat_id == IDW'(NREQ - 1)) ? '0 : lat_id + IDW'(1);

    // Control FSM: capture on grant, wait one cycle for the core, hold response
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            ptr         <= '0;
            lat_id      <= '0;
            lat         <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        lat    <= sel_req;
                        lat_id <= grant_id;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr         <= ptr_next;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    bitcnt_core u_core (
        .clock (clock),
        .clz   (lat.op == OP_CLZ),
        .ctz   (lat.op == OP_CTZ),
        .rs1   (lat.rs1),
        .rd    (core_rd)
    );

    // Core output is free-running, so only expose it while a response is valid
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = lat_id;
    assign bus.rsp_rd    = rsp_valid_q ? XLEN'(core_rd) : '0;

`ifdef BITCNT_ARB_STATS_EN
    // Count completed responses and cycles spent stalled by the consumer
    always_ff @(posedge clock) begin
        if (!resetn) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else if (state == RESP) begin
            if (bus.rsp_ready) stat_ops   <= stat_ops + 32'd1;
            else               stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bitcnt_arbiter.sv
// Scoreboard bench for bitcnt_arbiter: stimulus pushes expected {id, rd} at
// grant time, a negedge monitor pops and compares on every response handshake.
// Stats checks are compiled when BITCNT_ARB_STATS_EN is defined.
module tb_bitcnt_arbiter;
    import bitcnt_pkg::*;

    localparam int NREQ = 4;

    logic clock;
    logic resetn;
`ifdef BITCNT_ARB_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_stall;
`endif

    bitcnt_arbiter_if #(.NREQ(NREQ), .XLEN(32)) bus ();

    bitcnt_arbiter #(.NREQ(NREQ), .XLEN(32)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
`ifdef BITCNT_ARB_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clock) begin
        if (resetn === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got id %0d rd %0h expected no response", bus.rsp_id, bus.rsp_rd);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
                chk("rsp_rd", 64'(bus.rsp_rd), 64'(mon_e.rd));
            end
        end
    end

    // Issue one request from requester id; expected response queued on grant
    task automatic send(input int id, input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] exp);
        bit got;
        got = 1'b0;
        @(posedge clock); #1;
        bus.req_op[2*id +: 2]   = op;
        bus.req_rs1[32*id +: 32] = rs1;
        bus.req_valid[id]       = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (bus.req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout: requester %0d got no ready, expected ready within 20 cycles", id);
        end else begin
            chk("grant_onehot", 64'(bus.req_ready), 64'(1) << id);
            sb.push_back('{id, exp});
        end
        @(posedge clock); #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_grant(input string nm, output bit got);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (bus.req_ready != '0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no ready, expected a grant within 20 cycles", nm);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clock);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Directed vectors: requester, op, operand, hand-computed result
    int          v_id  [10] = '{1, 2, 3, 0, 1, 2, 0, 1, 2, 3};
    logic [1:0]  v_op  [10] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00};
    logic [31:0] v_rs1 [10] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_00F0,
                                32'h0000_0100, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'hA5A5_A5A5};
    logic [31:0] v_exp [10] = '{32, 32, 32, 0, 4, 8, 0, 31, 31, 16};

    // Round-robin operands per requester
    logic [1:0]  rr_op  [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    logic [31:0] rr_rs1 [4] = '{32'h0000_000F, 32'h0000_0400, 32'h0040_0000, 32'hFFFF_0000};
    logic [31:0] rr_exp [4] = '{4, 10, 9, 16};

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        bit got;
        int last;
        resetn        = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_rs1   = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, with requests pending
        @(posedge clock); #1;
        bus.req_valid = 4'hF;
        @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_rd", 64'(bus.rsp_rd), 64'd0);
        @(posedge clock); #1;
        bus.req_valid = '0;
        resetn = 1'b1;

        // Single clz op with exact timing
        @(posedge clock); #1;
        bus.req_op[1:0]  = OP_CLZ;
        bus.req_rs1[31:0] = 32'h0001_0000;
        bus.req_valid    = 4'b0001;
        @(negedge clock);
        chk("single_ready", 64'(bus.req_ready), 64'b0001);
        sb.push_back('{0, 32'd15});
        @(posedge clock); #1;
        bus.req_valid = '0;
        @(negedge clock);
        chk("single_exec_nvalid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clock);
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_rsp_rd", 64'(bus.rsp_rd), 64'd15);
        drain();

        // Directed result vectors, last one from requester 3 leaves ptr at 0
        for (int i = 0; i < 10; i++) begin
            send(v_id[i], v_op[i], v_rs1[i], v_exp[i]);
            drain();
        end

        // Round-robin with all requesters held valid
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            bus.req_op[2*i +: 2]   = rr_op[i];
            bus.req_rs1[32*i +: 32] = rr_rs1[i];
        end
        bus.req_valid = 4'hF;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant("rr_timeout", got);
            if (got) begin
                chk("rr_grant", 64'(bus.req_ready), 64'(1) << (g % 4));
                sb.push_back('{g % 4, rr_exp[g % 4]});
                if (g > 0) chk("rr_spacing", 64'(cyc - last), 64'd3);
                last = cyc;
            end
        end
        @(posedge clock); #1;
        bus.req_valid = '0;
        drain();

        // Backpressure: ptr is 1, only requester 2 valid
        @(posedge clock); #1;
        bus.req_op[5:4]   = OP_CLZ;
        bus.req_rs1[95:64] = 32'h0000_0001;
        bus.req_valid     = 4'b0100;
        wait_grant("bp_timeout", got);
        chk("bp_grant", 64'(bus.req_ready), 64'b0100);
        sb.push_back('{2, 32'd31});
        @(posedge clock); #1;
        bus.req_op[1:0]   = OP_CPOP;
        bus.req_rs1[31:0] = 32'h0000_0003;
        bus.req_valid     = 4'b0001;
        bus.rsp_ready     = 1'b0;
        @(negedge clock);
        chk("bp_exec_ready", 64'(bus.req_ready), 64'd0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            chk("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_hold_id", 64'(bus.rsp_id), 64'd2);
            chk("bp_hold_rd", 64'(bus.rsp_rd), 64'd31);
            chk("bp_hold_ready", 64'(bus.req_ready), 64'd0);
        end
        @(posedge clock); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        chk("bp_hs_valid", 64'(bus.rsp_valid), 64'd1);
        @(negedge clock);
        chk("bp_next_grant", 64'(bus.req_ready), 64'b0001);
        sb.push_back('{0, 32'd2});
        @(posedge clock); #1;
        bus.req_valid = '0;
        drain();

        // Reset in EXEC drops the op and rewinds ptr
        @(posedge clock); #1;
        bus.req_op[7:6]     = OP_CPOP;
        bus.req_rs1[127:96] = 32'h0000_00FF;
        bus.req_valid       = 4'b1000;
        wait_grant("rst_mid_timeout", got);
        chk("rst_mid_grant", 64'(bus.req_ready), 64'b1000);
        @(posedge clock); #1;
        bus.req_valid = '0;
        resetn = 1'b0;
        @(negedge clock);
        chk("rst_mid_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clock);
        chk("rst_mid_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_mid_rd", 64'(bus.rsp_rd), 64'd0);
        @(negedge clock);
        chk("rst_mid_valid2", 64'(bus.rsp_valid), 64'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        bus.req_op[3:2]   = OP_CTZ;
        bus.req_rs1[63:32] = 32'h0000_0008;
        bus.req_op[5:4]   = OP_CPOP;
        bus.req_rs1[95:64] = 32'h0000_0007;
        bus.req_valid     = 4'b0110;
        @(negedge clock);
        chk("rst_post_grant", 64'(bus.req_ready), 64'b0010);
        sb.push_back('{1, 32'd3});
        @(posedge clock); #1;
        bus.req_valid = '0;
        drain();

`ifdef BITCNT_ARB_STATS_EN
        // Statistics: 3 ops, one stalled for 4 cycles
        @(posedge clock); #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("stat_ops_rst", 64'(stat_ops), 64'd0);
        chk("stat_stall_rst", 64'(stat_stall), 64'd0);
        send(0, OP_CPOP, 32'h0000_0001, 32'd1);
        drain();
        send(1, OP_CPOP, 32'h0000_0003, 32'd2);
        drain();
        @(posedge clock); #1;
        bus.req_op[5:4]   = OP_CPOP;
        bus.req_rs1[95:64] = 32'h0000_0007;
        bus.req_valid     = 4'b0100;
        wait_grant("stat_timeout", got);
        sb.push_back('{2, 32'd3});
        @(posedge clock); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        repeat (4) @(negedge clock);
        @(posedge clock); #1;
        bus.rsp_ready = 1'b1;
        drain();
        @(posedge clock);
        @(negedge clock);
        chk("stat_ops", 64'(stat_ops), 64'd3);
        chk("stat_stall", 64'(stat_stall), 64'd4);
`endif

        repeat (3) @(negedge clock);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
